// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequencer and arbiter for the single shared memory port. Two requesters
//   (instruction fetch = IF, execute-stage data access = EX) compete for the
//   port. The winner's address, write data and direction are registered onto
//   the memory interface. The block then waits for MFC, bounded by a timeout,
//   and returns read data together with a one-cycle acknowledge to the owner.
//
//   Ports
//     clk, rst        clock (rising edge); asynchronous active-low reset
//     if_req/if_addr  IF read request (held until if_ack), read address
//     if_ack          one-cycle completion pulse to IF
//     ex_req/ex_we    EX request (held until ex_ack), 1=write 0=read
//     ex_addr         EX address
//     ex_wdata        EX write data
//     ex_ack          one-cycle completion pulse to EX
//     rdata           captured read data, held until the next capture
//     err             pulses with the ack of an access that timed out
//     memEN/RW        memory enable, 1=read 0=write
//     mem_addr        registered address to the memory
//     mem_wdata       registered write data to the memory
//     mem_rdata       memory read data
//     MFC             memory function complete
//     busy            high whenever the sequencer is not idle
//
//   Timing (edge k = IDLE edge that samples the request)
//     k   : IDLE  -> ISSUE, owner and address latched
//     k+1 : ISSUE -> WAIT, memEN rises
//     k+2+: WAIT samples MFC; the ack is visible in the cycle after the edge
//           that sees MFC (or after the TIMEOUT-th WAIT edge)
//     then: DONE  -> IDLE, round-robin pointer updated
//
//   TIMEOUT must lie in 2..255; the wait counter is 8 bits wide.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              ex_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              memEN,
  output logic              RW,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              MFC,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_EX = 1'b1} owner_t;

  // The counter holds the number of WAIT edges already spent without MFC.
  // Matching TIMEOUT-1 therefore identifies the TIMEOUT-th WAIT edge.
  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  owner_t     owner;
  owner_t     last;
  logic [7:0] wcnt;
  logic       grant_if;

  // IF wins when it is the only requester, or when both request and EX was
  // the requester served most recently.
  always_comb begin
    grant_if = if_req && (!ex_req || (last == OWN_EX));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      last      <= OWN_EX;
      wcnt      <= '0;
      memEN     <= 1'b0;
      RW        <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      if_ack    <= 1'b0;
      ex_ack    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // ack and err are single-cycle pulses; they default low every cycle.
      if_ack <= 1'b0;
      ex_ack <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (if_req || ex_req) begin
            state <= ISSUE;
            busy  <= 1'b1;
            if (grant_if) begin
              owner    <= OWN_IF;
              mem_addr <= if_addr;
              RW       <= 1'b1;  // fetches are always reads
            end else begin
              owner     <= OWN_EX;
              mem_addr  <= ex_addr;
              mem_wdata <= ex_wdata;
              RW        <= !ex_we;
            end
          end
        end

        ISSUE: begin
          memEN <= 1'b1;
          wcnt  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // MFC is checked before the timeout. An MFC on the last allowed
          // edge therefore completes normally.
          if (MFC || (wcnt == WCNT_LAST)) begin
            if (MFC) begin
              if (RW) rdata <= mem_rdata;
            end else begin
              err   <= 1'b1;
              rdata <= '0;
            end
            memEN  <= 1'b0;
            wcnt   <= '0;
            if_ack <= (owner == OWN_IF);
            ex_ack <= (owner == OWN_EX);
            state  <= DONE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end

        DONE: begin
          last  <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Each transaction computes its expected
//   result from a small model (round-robin pointer, held rdata, held wdata).
//   The result is pushed to a scoreboard queue and popped when the ack appears.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic          ex_req = 1'b0;
  logic          ex_we = 1'b0;
  logic [AW-1:0] ex_addr = '0;
  logic [DW-1:0] ex_wdata = '0;
  logic          ex_ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          memEN;
  logic          RW;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          MFC = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_ack(ex_ack),
    .rdata(rdata), .err(err), .memEN(memEN), .RW(RW),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .MFC(MFC), .busy(busy)
  );

  typedef struct {
    logic          win_if;
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          m_last_ex = 1'b1;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_wdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction. mfc_n selects the WAIT edge with MFC high; a
  // value of 0 means MFC never arrives. early raises MFC across the IDLE and
  // ISSUE edges. drop releases both requests when the ack is seen.
  task automatic xact(input bit ifr, input bit exr, input bit we,
                      input logic [AW-1:0] ia, input logic [AW-1:0] ea,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                      input int mfc_n, input bit early, input bit drop,
                      input string tag);
    exp_t e, g;
    bit   to, acked;
    int   w;
    e.win_if = (ifr && exr) ? m_last_ex : ifr;
    to       = (mfc_n < 1) || (mfc_n > TO);
    e.addr   = e.win_if ? ia : ea;
    e.rw     = e.win_if ? 1'b1 : !we;
    if (!e.win_if) m_wdata = wd;
    e.wdata  = m_wdata;
    if (to) m_rdata = '0;
    else if (e.rw) m_rdata = rd;
    e.rdata  = m_rdata;
    e.err    = to;
    sb.push_back(e);

    if_req = ifr; ex_req = exr; if_addr = ia; ex_addr = ea;
    ex_we = we; ex_wdata = wd; mem_rdata = rd; MFC = early;
    @(negedge clk);  // past edge k: ISSUE
    chk({tag, ".issue_en"}, memEN, 0);
    chk({tag, ".issue_busy"}, busy, 1);
    @(negedge clk);  // past edge k+1: WAIT
    MFC = 1'b0;
    chk({tag, ".wait_en"}, memEN, 1);
    chk({tag, ".wait_noack"}, if_ack | ex_ack, 0);

    acked = 1'b0;
    w = 0;
    while (!acked && w < TO + 3) begin
      w++;
      MFC = (w == mfc_n);
      @(negedge clk);
      MFC = 1'b0;
      acked = (if_ack === 1'b1) || (ex_ack === 1'b1);
    end
    chk({tag, ".acked"}, acked, 1);
    chk({tag, ".ack_edge"}, w, to ? TO : mfc_n);

    g = sb.pop_front();
    chk({tag, ".if_ack"}, if_ack, g.win_if);
    chk({tag, ".ex_ack"}, ex_ack, !g.win_if);
    chk({tag, ".rdata"}, rdata, g.rdata);
    chk({tag, ".err"}, err, g.err);
    chk({tag, ".addr"}, mem_addr, g.addr);
    chk({tag, ".rw"}, RW, g.rw);
    chk({tag, ".wdata"}, mem_wdata, g.wdata);
    chk({tag, ".done_en"}, memEN, 0);
    if (drop) begin if_req = 1'b0; ex_req = 1'b0; end
    m_last_ex = !g.win_if;
    @(negedge clk);  // past DONE edge: IDLE
    chk({tag, ".ack_pulse"}, {if_ack, ex_ack, err}, 3'b000);
    chk({tag, ".idle_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst.memEN", memEN, 0);
    chk("rst.RW", RW, 1);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.acks_err_busy", {if_ack, ex_ack, err, busy}, 4'b0000);
    rst = 1'b1;
    @(negedge clk);

    // MFC while IDLE with no request: nothing happens
    MFC = 1'b1;
    repeat (3) @(negedge clk);
    MFC = 1'b0;
    chk("spur.idle", {busy, memEN, if_ack, ex_ack}, 4'b0000);

    // Round robin: both requests held high for three transactions
    xact(1, 1, 0, 16'h0100, 16'h0300, 16'h0000, 16'h1111, 1, 0, 0, "rr1");
    xact(1, 1, 0, 16'h0100, 16'h0300, 16'h0000, 16'h2222, 2, 0, 0, "rr2");
    xact(1, 1, 0, 16'h0100, 16'h0300, 16'h0000, 16'h3333, 1, 0, 1, "rr3");

    // Single IF read, MFC on the second WAIT edge
    xact(1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 2, 0, 1, "ifrd");

    // Asynchronous reset during WAIT; the last access was an IF read
    if_req = 1'b1; if_addr = 16'h0040;
    @(negedge clk); @(negedge clk);
    chk("arst.pre_en", memEN, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst.memEN", memEN, 0);
    chk("arst.busy", busy, 0);
    chk("arst.acks", {if_ack, ex_ack, err}, 3'b000);
    chk("arst.rdata", rdata, 0);
    chk("arst.addr", mem_addr, 0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_last_ex = 1'b1; m_rdata = '0; m_wdata = '0;
    @(negedge clk);

    // The first tie after reset goes to IF
    xact(1, 1, 0, 16'h0055, 16'h0066, 16'h0000, 16'h4444, 1, 0, 1, "post_rst_tie");

    // EX write, MFC on the first WAIT edge; rdata is left unchanged
    xact(0, 1, 1, 16'h0000, 16'h0200, 16'h1234, 16'hDEAD, 1, 0, 1, "exwr");

    // Timeout: MFC never arrives
    xact(1, 0, 0, 16'h0020, 16'h0000, 16'h0000, 16'h9999, 0, 0, 1, "tmo");

    // MFC on the final allowed WAIT edge wins over the timeout
    xact(1, 0, 0, 16'h0030, 16'h0000, 16'h0000, 16'hCAFE, TO, 0, 1, "tmo_edge");

    // MFC during IDLE and ISSUE is ignored; completion still needs MFC in WAIT
    xact(0, 1, 0, 16'h0000, 16'h0400, 16'h0000, 16'h5A5A, 3, 1, 1, "spur_mfc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
